// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
//   Bundles the two requester channels and the response channel of the shared
//   ALU arbiter.
//   master : requester/consumer side (drives req_valid, operands, rsp_ready)
//   slave  : arbiter side (drives req_ready and the registered response)
//   Signals:
//     req_valid[1:0]   per-requester valid ([0]=req0, [1]=req1)
//     req_ready[1:0]   one-hot accept strobe
//     reqN_a/b/ctrl    per-requester operands and ALU control code
//     rsp_valid/ready  response handshake
//     rsp_id           requester that issued the operation
//     rsp_result/zero  ALU result and zero flag
//     rsp_err          illegal control code flag
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
    parameter int WIDTH = 48,
    parameter int ID_W  = 1
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [3:0]       req0_ctrl;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [3:0]       req1_ctrl;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [ID_W-1:0]  rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_err;

    modport master (
        output req_valid, req0_a, req0_b, req0_ctrl, req1_a, req1_b, req1_ctrl, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req0_a, req0_b, req0_ctrl, req1_a, req1_b, req1_ctrl, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational ALU between two requesters. Round-robin grant,
//   one operation in flight, registered response tagged with requester ID.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high
//     bus    alu_arbiter_if slave modport (request channels + response channel)
//   Flow per operation: IDLE (accept) -> EXEC (ALU evaluates) -> RESP (hold
//   until rsp_ready), so accept at cycle T gives rsp_valid at T+2.
// -----------------------------------------------------------------------------

// Combinational ALU: AND/OR/ADD/SUB/SLT/NOR, anything else flagged illegal.
module alu #(
    parameter int WIDTH = 48
) (
    input  logic [3:0]              ctrl,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic [WIDTH-1:0]        result,
    output logic                    zero,
    output logic                    illegal
);
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    // Operation decode; both operands signed so '<' is a signed compare.
    always_comb begin
        result  = ZERO;
        illegal = 1'b0;
        case (ctrl)
            4'h0:    result = a & b;
            4'h1:    result = a | b;
            4'h2:    result = a + b;
            4'h6:    result = a - b;
            4'h7:    result = (a < b) ? ONE : ZERO;
            4'hC:    result = ~(a | b);
            default: begin
                result  = ZERO;
                illegal = 1'b1;
            end
        endcase
        zero = (result == ZERO);
    end
endmodule

module alu_arbiter #(
    parameter int WIDTH = 48,
    parameter int ID_W  = 1
) (
    input  logic          clk,
    input  logic          reset,
    alu_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

    state_t           state_q, state_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_err_q, rsp_err_d;
    logic [1:0]       req_ready_s;
    logic             grant_s;
    logic [WIDTH-1:0] alu_result_s;
    logic             alu_zero_s;
    logic             alu_illegal_s;

    alu #(.WIDTH(WIDTH)) u_alu (
        .ctrl    (ctrl_q),
        .a       (a_q),
        .b       (b_q),
        .result  (alu_result_s),
        .zero    (alu_zero_s),
        .illegal (alu_illegal_s)
    );

    // Next-state, grant and response-capture logic.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        a_d          = a_q;
        b_d          = b_q;
        ctrl_d       = ctrl_q;
        id_d         = id_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        req_ready_s  = 2'b00;
        // Preferred requester wins if it is asking, otherwise the other one.
        grant_s      = bus.req_valid[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid != 2'b00) begin
                    req_ready_s = grant_s ? 2'b10 : 2'b01;
                    id_d        = grant_s;
                    a_d         = grant_s ? bus.req1_a    : bus.req0_a;
                    b_d         = grant_s ? bus.req1_b    : bus.req0_b;
                    ctrl_d      = grant_s ? bus.req1_ctrl : bus.req0_ctrl;
                    state_d     = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                rsp_id_d = id_q;
                if (alu_illegal_s) begin
                    rsp_result_d = ZERO;
                    rsp_zero_d   = 1'b1;
                    rsp_err_d    = 1'b1;
                end else begin
                    rsp_result_d = alu_result_s;
                    rsp_zero_d   = alu_zero_s;
                    rsp_err_d    = 1'b0;
                end
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    // Hand priority to the requester that was not just served.
                    rr_ptr_d = ~rsp_id_q;
                    state_d  = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= 1'b0;
            a_q          <= ZERO;
            b_q          <= ZERO;
            ctrl_q       <= 4'h0;
            id_q         <= {ID_W{1'b0}};
            rsp_id_q     <= {ID_W{1'b0}};
            rsp_result_q <= ZERO;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            a_q          <= a_d;
            b_q          <= b_d;
            ctrl_q       <= ctrl_d;
            id_q         <= id_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign bus.req_ready  = req_ready_s;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_err    = rsp_err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed and randomized stimulus for alu_arbiter, checked against a
//   reference model of the ALU operations and the round-robin grant rule.
//   Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
    logic clk;
    logic reset;
    int   tests;
    int   fails;
    bit   pref;   // requester that currently holds round-robin priority

    alu_arbiter_if #(.WIDTH(48), .ID_W(1)) bus ();

    alu_arbiter #(.WIDTH(48), .ID_W(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference ALU written from the operation table.
    function automatic logic [47:0] ref_res(input logic [3:0] c, input logic [47:0] a, input logic [47:0] b);
        longint sa;
        longint sb;
        sa = longint'({{16{a[47]}}, a});
        sb = longint'({{16{b[47]}}, b});
        case (c)
            4'h0:    return a & b;
            4'h1:    return a | b;
            4'h2:    return a + b;
            4'h6:    return a - b;
            4'h7:    return (sa < sb) ? 48'd1 : 48'd0;
            4'hC:    return ~(a | b);
            default: return 48'd0;
        endcase
    endfunction

    function automatic bit ref_illegal(input logic [3:0] c);
        return !(c inside {4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC});
    endfunction

    function automatic logic [47:0] rnd48();
        logic [63:0] t;
        logic [47:0] special [4];
        special[0] = 48'h0;
        special[1] = 48'hFFFF_FFFF_FFFF;
        special[2] = 48'h8000_0000_0000;
        special[3] = 48'h7FFF_FFFF_FFFF;
        t = {$urandom(), $urandom()};
        if ($urandom_range(0, 3) == 0) return special[$urandom_range(0, 3)];
        return t[47:0];
    endfunction

    // One complete operation; entered and left on a falling edge in IDLE.
    task automatic run_op(input logic [1:0] v,
                          input logic [3:0] c0, input logic [47:0] a0, input logic [47:0] b0,
                          input logic [3:0] c1, input logic [47:0] a1, input logic [47:0] b1,
                          input int stall);
        bit          g;
        logic [3:0]  c;
        logic [47:0] er;
        bit          ee;
        bit          ez;
        bus.req_valid = v;
        bus.req0_ctrl = c0; bus.req0_a = a0; bus.req0_b = b0;
        bus.req1_ctrl = c1; bus.req1_a = a1; bus.req1_b = b1;
        bus.rsp_ready = 1'b1;
        g  = v[pref] ? pref : ~pref;
        c  = g ? c1 : c0;
        ee = ref_illegal(c);
        er = g ? ref_res(c, a1, b1) : ref_res(c, a0, b0);
        ez = ee || (er == 48'd0);
        #1;
        check("accept_ready", 64'(bus.req_ready), g ? 64'd2 : 64'd1);
        @(negedge clk);
        check("exec_ready", 64'(bus.req_ready), 64'd0);
        check("exec_valid", 64'(bus.rsp_valid), 64'd0);
        // Operands must have been captured at accept; scramble the live ones.
        bus.req0_a = rnd48(); bus.req0_b = rnd48(); bus.req0_ctrl = 4'($urandom_range(0, 15));
        bus.req1_a = rnd48(); bus.req1_b = rnd48(); bus.req1_ctrl = 4'($urandom_range(0, 15));
        bus.rsp_ready = (stall == 0);
        @(negedge clk);
        for (int i = 0; i <= stall; i++) begin
            if (i > 0) @(negedge clk);
            check("rsp_valid", 64'(bus.rsp_valid), 64'd1);
            check("rsp_id", 64'(bus.rsp_id), 64'(g));
            check("rsp_result", 64'(bus.rsp_result), 64'(ee ? 48'd0 : er));
            check("rsp_zero", 64'(bus.rsp_zero), 64'(ez));
            check("rsp_err", 64'(bus.rsp_err), 64'(ee));
            check("resp_ready", 64'(bus.req_ready), 64'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("rsp_drop", 64'(bus.rsp_valid), 64'd0);
        pref = ~g;
    endtask

    task automatic idle_cycle();
        bus.req_valid = 2'b00;
        #1;
        check("idle_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        check("idle_valid", 64'(bus.rsp_valid), 64'd0);
    endtask

    initial begin
        logic [3:0] codes [8];
        tests = 0;
        fails = 0;
        pref  = 1'b0;
        codes[0] = 4'h0; codes[1] = 4'h1; codes[2] = 4'h2; codes[3] = 4'h6;
        codes[4] = 4'h7; codes[5] = 4'hC; codes[6] = 4'h3; codes[7] = 4'hF;
        reset = 1'b1;
        bus.req_valid = 2'b00; bus.rsp_ready = 1'b0;
        bus.req0_a = 48'd0; bus.req0_b = 48'd0; bus.req0_ctrl = 4'h0;
        bus.req1_a = 48'd0; bus.req1_b = 48'd0; bus.req1_ctrl = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_ready", 64'(bus.req_ready), 64'd0);
        check("rst_id", 64'(bus.rsp_id), 64'd0);
        check("rst_result", 64'(bus.rsp_result), 64'd0);
        check("rst_zero", 64'(bus.rsp_zero), 64'd0);
        check("rst_err", 64'(bus.rsp_err), 64'd0);
        reset = 1'b0;

        // Directed: ADD giving all ones.
        run_op(2'b01, 4'h2, 48'h5555_5555_5555, 48'hAAAA_AAAA_AAAA, 4'h0, 48'd0, 48'd0, 0);
        idle_cycle();
        // Directed: both valid continuously, grants alternate.
        run_op(2'b11, 4'h6, 48'd1, 48'd1, 4'hC, 48'd0, 48'd0, 0);
        run_op(2'b11, 4'h6, 48'd1, 48'd1, 4'hC, 48'd0, 48'd0, 0);
        run_op(2'b11, 4'h6, 48'd1, 48'd1, 4'hC, 48'd0, 48'd0, 0);
        idle_cycle();
        // Directed: signed SLT.
        run_op(2'b10, 4'h0, 48'd0, 48'd0, 4'h7, 48'hFFFF_FFFF_FFFD, 48'hFFFF_FFFF_FFFB, 0);
        run_op(2'b10, 4'h0, 48'd0, 48'd0, 4'h7, 48'd3, 48'd5, 0);
        // Directed: response back-pressure with both requesters waiting.
        run_op(2'b11, 4'h1, 48'h1234_0000_0000, 48'h0000_0000_5678, 4'h2, 48'd7, 48'd9, 5);
        idle_cycle();
        // Directed: illegal control then a legal one.
        run_op(2'b01, 4'h3, 48'd10, 48'd20, 4'h0, 48'd0, 48'd0, 0);
        run_op(2'b01, 4'h2, 48'd10, 48'd20, 4'h0, 48'd0, 48'd0, 0);

        // Reset during EXEC: priority currently with req1; reset must return it to req0.
        bus.req_valid = 2'b01;
        bus.req0_ctrl = 4'h2; bus.req0_a = 48'd1; bus.req0_b = 48'd2;
        #1;
        check("pre_rst_ready", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        bus.req_valid = 2'b00;
        @(negedge clk);
        check("mid_rst_valid", 64'(bus.rsp_valid), 64'd0);
        check("mid_rst_result", 64'(bus.rsp_result), 64'd0);
        check("mid_rst_id", 64'(bus.rsp_id), 64'd0);
        check("mid_rst_zero", 64'(bus.rsp_zero), 64'd0);
        check("mid_rst_err", 64'(bus.rsp_err), 64'd0);
        reset = 1'b0;
        pref  = 1'b0;
        idle_cycle();
        run_op(2'b11, 4'h0, 48'hF0F0_F0F0_F0F0, 48'hFF00_FF00_FF00, 4'h1, 48'd0, 48'd0, 0);
        run_op(2'b10, 4'h0, 48'd0, 48'd0, 4'h2, 48'hFFFF_FFFF_FFFF, 48'd1, 0);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 4) == 0) idle_cycle();
            run_op(2'($urandom_range(1, 3)),
                   codes[$urandom_range(0, 7)], rnd48(), rnd48(),
                   codes[$urandom_range(0, 7)], rnd48(), rnd48(),
                   int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
